// File: rtl/tlb_page_walker.sv
// Two-level page-table walker: fetches PDE then PTE over a single-outstanding read
// port and emits a one-cycle TLB update, or a directory-fault completion.
module tlb_page_walker #(
  parameter int ASID_WIDTH    = 8,
  parameter int PAGE_NUM_BITS = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     walk_req_valid,
  output logic                     walk_req_ready,
  input  logic [PAGE_NUM_BITS-1:0] walk_vpage_idx,
  input  logic [ASID_WIDTH-1:0]    walk_asid,
  input  logic [31:0]              page_dir_base,
  input  logic                     walk_abort,
  output logic                     mem_read_en,
  output logic [31:0]              mem_read_addr,
  input  logic                     mem_read_ready,
  input  logic                     mem_read_valid,
  input  logic [31:0]              mem_read_data,
  output logic                     tlb_update_en,
  output logic [PAGE_NUM_BITS-1:0] tlb_update_vpage_idx,
  output logic [ASID_WIDTH-1:0]    tlb_update_asid,
  output logic [PAGE_NUM_BITS-1:0] tlb_update_ppage_idx,
  output logic                     tlb_update_present,
  output logic                     tlb_update_exe_writable,
  output logic                     tlb_update_supervisor,
  output logic                     tlb_update_global,
  output logic                     walk_done,
  output logic                     walk_fault
);

  typedef enum logic [2:0] {
    IDLE, PDE_REQ, PDE_WAIT, PTE_REQ, PTE_WAIT, UPDATE, FAULT, DRAIN
  } state_e;

  state_e                   state_q, state_d;
  logic [PAGE_NUM_BITS-1:0] vpage_q, vpage_d;
  logic [ASID_WIDTH-1:0]    asid_q, asid_d;
  logic [PAGE_NUM_BITS-1:0] base_q, base_d;
  logic [PAGE_NUM_BITS-1:0] pde_q, pde_d;
  logic [PAGE_NUM_BITS-1:0] ppage_q, ppage_d;
  logic [3:0]               attr_q, attr_d;

  logic unusedBits;
  assign unusedBits = ^{page_dir_base[11:0], mem_read_data[11:4]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vpage_q <= '0;
      asid_q  <= '0;
      base_q  <= '0;
      pde_q   <= '0;
      ppage_q <= '0;
      attr_q  <= '0;
    end else begin
      state_q <= state_d;
      vpage_q <= vpage_d;
      asid_q  <= asid_d;
      base_q  <= base_d;
      pde_q   <= pde_d;
      ppage_q <= ppage_d;
      attr_q  <= attr_d;
    end
  end

  // An abort with the read already handed to memory must drain its response first.
  always_comb begin
    state_d = state_q;
    vpage_d = vpage_q;
    asid_d  = asid_q;
    base_d  = base_q;
    pde_d   = pde_q;
    ppage_d = ppage_q;
    attr_d  = attr_q;
    unique case (state_q)
      IDLE: begin
        if (walk_req_valid && walk_req_ready) begin
          vpage_d = walk_vpage_idx;
          asid_d  = walk_asid;
          base_d  = page_dir_base[31:12];
          state_d = PDE_REQ;
        end
      end
      PDE_REQ, PTE_REQ: begin
        if (walk_abort) begin
          state_d = mem_read_ready ? DRAIN : IDLE;
        end else if (mem_read_ready) begin
          state_d = (state_q == PDE_REQ) ? PDE_WAIT : PTE_WAIT;
        end
      end
      PDE_WAIT: begin
        if (mem_read_valid) begin
          if (walk_abort) begin
            state_d = IDLE;
          end else begin
            pde_d   = mem_read_data[31:12];
            state_d = mem_read_data[0] ? PTE_REQ : FAULT;
          end
        end else if (walk_abort) begin
          state_d = DRAIN;
        end
      end
      PTE_WAIT: begin
        if (mem_read_valid) begin
          if (walk_abort) begin
            state_d = IDLE;
          end else begin
            ppage_d = mem_read_data[31:12];
            attr_d  = mem_read_data[3:0];
            state_d = UPDATE;
          end
        end else if (walk_abort) begin
          state_d = DRAIN;
        end
      end
      UPDATE, FAULT: state_d = IDLE;
      DRAIN: begin
        if (mem_read_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign walk_req_ready = (state_q == IDLE) && !walk_abort;
  assign mem_read_en    = (state_q == PDE_REQ) || (state_q == PTE_REQ);

  always_comb begin
    mem_read_addr = '0;
    if (state_q == PDE_REQ) begin
      mem_read_addr = {base_q, vpage_q[19:10], 2'b00};
    end else if (state_q == PTE_REQ) begin
      mem_read_addr = {pde_q, vpage_q[9:0], 2'b00};
    end
  end

  assign tlb_update_en           = (state_q == UPDATE) && !walk_abort;
  assign walk_done               = ((state_q == UPDATE) || (state_q == FAULT)) && !walk_abort;
  assign walk_fault              = (state_q == FAULT) && !walk_abort;
  assign tlb_update_vpage_idx    = vpage_q;
  assign tlb_update_asid         = asid_q;
  assign tlb_update_ppage_idx    = ppage_q;
  assign tlb_update_present      = attr_q[0];
  assign tlb_update_exe_writable = attr_q[1];
  assign tlb_update_supervisor   = attr_q[2];
  assign tlb_update_global       = attr_q[3];

  // Read data may only arrive while a read is genuinely outstanding.
  memValidInWait: assert property (@(posedge clk) disable iff (!reset)
    mem_read_valid |-> (state_q inside {PDE_WAIT, PTE_WAIT, DRAIN}));

endmodule
